// File: rtl/uart_rx_if.sv
// Received-byte bundle of the UART receiver.
// The receiver drives it through the master modport; consumers read it through the slave modport.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_active;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output rx_active
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input parity_err,
    input frame_err,
    input rx_active
  );
endinterface

// File: rtl/uart_rx.sv
// 8E1 UART receiver: start, 8 data bits LSB first, even parity, stop.
// Each bit is sampled at mid-bit by a clock-count timer, and every byte is delivered with a one-cycle strobe.
module uart_rx #(
  parameter int BR       = 9600,
  parameter int CLK_RATE = 50_000_000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     rx_serial_in,
  uart_rx_if.master rx_out
);

  localparam int CPB = CLK_RATE / BR;
  localparam logic [15:0] CNT_BIT_END = 16'(CPB - 1);
  localparam logic [15:0] CNT_HALF    = 16'(CPB / 2 - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  if (CPB < 4 || CPB > 65535) begin : g_cpb_range
    $error("uart_rx: clocks per bit out of range");
  end

  logic        sync1_reg, rx_s_reg, rx_prev_reg;
  logic [2:0]  state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic        par_reg, par_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        perr_reg, perr_next;
  logic        ferr_reg, ferr_next;
  logic        sample_en, deliver;
  logic        fall, cnt_at_end, cnt_at_half;

  // The synchronizer idles high, so a low line at reset release is not seen as a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg   <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync1_reg   <= rx_serial_in;
      rx_s_reg    <= sync1_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  assign fall        = rx_prev_reg & ~rx_s_reg;
  assign cnt_at_end  = (cnt_reg == CNT_BIT_END);
  assign cnt_at_half = (cnt_reg == CNT_HALF);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 16'd1;
    idx_next   = idx_reg;
    par_next   = par_reg;
    sample_en  = 1'b0;
    deliver    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = 16'd0;
        if (fall) state_next = START;
      end
      START: begin
        if (cnt_at_half) begin
          cnt_next   = 16'd0;
          idx_next   = 3'd0;
          state_next = rx_s_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_at_end) begin
          cnt_next  = 16'd0;
          sample_en = 1'b1;
          if (idx_reg == 3'd7) state_next = PARITY;
          else                 idx_next   = idx_reg + 3'd1;
        end
      end
      PARITY: begin
        if (cnt_at_end) begin
          cnt_next   = 16'd0;
          par_next   = rx_s_reg;
          state_next = STOP;
        end
      end
      STOP: begin
        // IDLE is re-entered at the stop-bit centre, so a back-to-back start edge is caught.
        if (cnt_at_end) begin
          cnt_next   = 16'd0;
          deliver    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = 16'd0;
        state_next = IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_shift
    assign shift_next[gi] = (sample_en && idx_reg == 3'(gi)) ? rx_s_reg : shift_reg[gi];
  end

  // rx_s_reg at the delivery edge is the stop-bit sample.
  assign data_next  = deliver ? shift_reg : data_reg;
  assign perr_next  = deliver ? ((^shift_reg) ^ par_reg) : perr_reg;
  assign ferr_next  = deliver ? ~rx_s_reg : ferr_reg;
  assign valid_next = deliver;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      idx_reg   <= 3'd0;
      par_reg   <= 1'b0;
      shift_reg <= 8'd0;
      data_reg  <= 8'd0;
      valid_reg <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      par_reg   <= par_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
    end
  end

  assign rx_out.rx_data    = data_reg;
  assign rx_out.rx_valid   = valid_reg;
  assign rx_out.parity_err = perr_reg;
  assign rx_out.frame_err  = ferr_reg;
  assign rx_out.rx_active  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CPB=10. A frame-level model predicts each strobe's cycle and contents, plus the rx_active windows.
// The compare process checks every output on every falling clock edge outside reset.
module tb_uart_rx;

  logic clk = 1'b0;
  logic reset;
  logic line;
  int   cyc = 0;

  uart_rx_if rx_bus ();

  uart_rx #(.BR(100000), .CLK_RATE(1_000_000)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_serial_in (line),
    .rx_out       (rx_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  typedef struct {
    int lo;
    int hi;
  } win_t;

  exp_t exp_q[$];
  win_t wins[$];
  int   strobes[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   act_cnt = 0;
  logic [7:0] last_data;
  logic last_perr, last_ferr, exp_act, exp_vld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Frame timing for CPB=10: rx_active is high over cycles c+3..c+107, and the strobe comes at c+108.
  always @(negedge clk) begin
    if (reset) begin
      last_data = 8'h00;
      last_perr = 1'b0;
      last_ferr = 1'b0;
    end else begin
      exp_act = 1'b0;
      foreach (wins[i]) if (cyc >= wins[i].lo && cyc <= wins[i].hi) exp_act = 1'b1;
      check("rx_active", rx_bus.rx_active, exp_act);
      if (rx_bus.rx_active) act_cnt++;
      exp_vld = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("rx_valid", rx_bus.rx_valid, exp_vld);
      if (exp_vld) begin
        last_data = exp_q[0].data;
        last_perr = exp_q[0].perr;
        last_ferr = exp_q[0].ferr;
        void'(exp_q.pop_front());
      end
      if (rx_bus.rx_valid) strobes.push_back(cyc);
      check("rx_data", rx_bus.rx_data, last_data);
      check("parity_err", rx_bus.parity_err, last_perr);
      check("frame_err", rx_bus.frame_err, last_ferr);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Frame bits: [0] start, [8:1] data, [9] parity, [10] stop. Each bit lasts 10 clocks.
  task automatic send_bits(input logic [10:0] bits, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      line = bits[k / 10];
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop);
    exp_t e;
    win_t w;
    e.data = data;
    e.perr = (^data) ^ pbit;
    e.ferr = ~stop;
    e.cyc  = cyc + 108;
    exp_q.push_back(e);
    w.lo = cyc + 3;
    w.hi = cyc + 107;
    wins.push_back(w);
    send_bits({stop, pbit, data, 1'b0}, 110);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    tick(n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"}, rx_bus.rx_data, 0);
    check({tag, "_rx_valid"}, rx_bus.rx_valid, 0);
    check({tag, "_parity_err"}, rx_bus.parity_err, 0);
    check({tag, "_frame_err"}, rx_bus.frame_err, 0);
    check({tag, "_rx_active"}, rx_bus.rx_active, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t w;
    reset = 1'b1;
    line  = 1'b1;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(10);

    // Ideal frame
    act_cnt = 0;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(10);
    check("a5_data", rx_bus.rx_data, 8'hA5);
    check("a5_perr", rx_bus.parity_err, 0);
    check("a5_ferr", rx_bus.frame_err, 0);
    check("a5_active_len", act_cnt, 105);

    // Wrong parity bit
    send_frame(8'h01, 1'b0, 1'b1);
    idle(10);
    check("p01_data", rx_bus.rx_data, 8'h01);
    check("p01_perr", rx_bus.parity_err, 1);

    // Framing error, then the line is held low, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(50);
    check("f3c_data", rx_bus.rx_data, 8'h3C);
    check("f3c_ferr", rx_bus.frame_err, 1);
    idle(20);
    send_frame(8'h55, 1'b0, 1'b1);
    idle(10);
    check("f55_data", rx_bus.rx_data, 8'h55);
    check("f55_ferr", rx_bus.frame_err, 0);

    // A 3-clock glitch enters START briefly and is then rejected
    w.lo = cyc + 3;
    w.hi = cyc + 7;
    wins.push_back(w);
    line = 1'b0;
    tick(3);
    idle(20);
    check("glitch_data", rx_bus.rx_data, 8'h55);

    // Back-to-back frames
    strobes.delete();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(10);
    check("b2b_count", strobes.size(), 3);
    if (strobes.size() == 3) begin
      check("b2b_gap1", strobes[1] - strobes[0], 110);
      check("b2b_gap2", strobes[2] - strobes[1], 110);
    end
    check("b2b_data", rx_bus.rx_data, 8'h81);

    // Reset in the middle of data bit 4
    w.lo = cyc + 3;
    w.hi = cyc + 55;
    wins.push_back(w);
    send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 55);
    reset = 1'b1;
    line  = 1'b1;
    #1;
    check_all_zero("abort");
    tick(3);
    check_all_zero("abort_hold");
    reset = 1'b0;
    idle(10);
    send_frame(8'h7E, 1'b0, 1'b1);
    idle(10);
    check("r7e_data", rx_bus.rx_data, 8'h7E);
    check("r7e_perr", rx_bus.parity_err, 0);

    tick(20);
    check("pending_strobes", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
